// File: rtl/fm_int_dec.sv
// fm_int_dec: routes one upstream request to target 0 or 1 by address MSB.
// Define FM_INT_DEC_TIMEOUT_EN to abort transfers that wait P_TIMEOUT cycles.
module fm_int_dec #(
    parameter int         P_ADR_WIDTH  = 10,
    parameter int         P_BE_WIDTH   = 4,
    parameter int         P_DATA_WIDTH = 32,
    parameter logic [7:0] P_TIMEOUT    = 8'd255
) (
    input  logic                    clk_core,
    input  logic                    rst_x,
    input  logic                    i_req,
    input  logic                    i_wr,
    input  logic [P_ADR_WIDTH-1:0]  i_adrs,
    input  logic [P_BE_WIDTH-1:0]   i_be,
    input  logic [P_DATA_WIDTH-1:0] i_wd,
    output logic                    o_ack,
    output logic                    o_rstr,
    output logic [P_DATA_WIDTH-1:0] o_rd,
    output logic                    o_timeout,
    output logic                    o_req0,
    output logic                    o_wr0,
    output logic [P_ADR_WIDTH-1:0]  o_adrs0,
    output logic [P_BE_WIDTH-1:0]   o_be0,
    output logic [P_DATA_WIDTH-1:0] o_wd0,
    input  logic                    i_ack0,
    input  logic                    i_rstr0,
    input  logic [P_DATA_WIDTH-1:0] i_rd0,
    output logic                    o_req1,
    output logic                    o_wr1,
    output logic [P_ADR_WIDTH-1:0]  o_adrs1,
    output logic [P_BE_WIDTH-1:0]   o_be1,
    output logic [P_DATA_WIDTH-1:0] o_wd1,
    input  logic                    i_ack1,
    input  logic                    i_rstr1,
    input  logic [P_DATA_WIDTH-1:0] i_rd1
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDATA} state_t;
    state_t                  state;
    logic                    sel, wr, ack_q, to;
    logic [P_ADR_WIDTH-1:0]  adrs;
    logic [P_BE_WIDTH-1:0]   be;
    logic [P_DATA_WIDTH-1:0] wd;
    logic                    ack_sel, rstr_sel;
    logic [P_DATA_WIDTH-1:0] rd_sel;

    assign ack_sel  = sel ? i_ack1 : i_ack0;
    assign rstr_sel = sel ? i_rstr1 : i_rstr0;
    assign rd_sel   = sel ? i_rd1 : i_rd0;

`ifdef FM_INT_DEC_TIMEOUT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk_core or negedge rst_x)
        if (!rst_x) cnt <= '0;
        else cnt <= (state == IDLE || (state == WAIT_ACK && ack_sel)) ? '0 : cnt + 8'd1;
    assign to = (cnt == P_TIMEOUT) &&
                (state == WAIT_ACK ? !ack_sel : state == WAIT_RDATA && !rstr_sel);
`else
    assign to = 1'b0;
`endif

    assign o_ack     = state == WAIT_ACK && (ack_sel || to);
    assign o_rstr    = !wr && (state == WAIT_ACK ? (ack_sel && rstr_sel) || to
                                                 : state == WAIT_RDATA && (rstr_sel || to));
    assign o_rd      = !o_rstr ? '0 : to ? P_DATA_WIDTH'(32'hDEAD_BEEF) : rd_sel;
    assign o_timeout = to;
    assign o_wr0     = wr;
    assign o_adrs0   = adrs;
    assign o_be0     = be;
    assign o_wd0     = wd;
    assign o_wr1     = wr;
    assign o_adrs1   = adrs;
    assign o_be1     = be;
    assign o_wd1     = wd;

    // ack_q blocks re-acceptance while upstream is still dropping i_req after an ack
    always_ff @(posedge clk_core or negedge rst_x)
        if (!rst_x) begin
            state  <= IDLE;
            sel    <= 1'b0;
            wr     <= 1'b0;
            adrs   <= '0;
            be     <= '0;
            wd     <= '0;
            o_req0 <= 1'b0;
            o_req1 <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= o_ack;
            case (state)
                IDLE: if (i_req && !ack_q) begin
                    sel    <= i_adrs[P_ADR_WIDTH-1];
                    wr     <= i_wr;
                    adrs   <= i_adrs;
                    be     <= i_be;
                    wd     <= i_wd;
                    o_req0 <= !i_adrs[P_ADR_WIDTH-1];
                    o_req1 <= i_adrs[P_ADR_WIDTH-1];
                    state  <= WAIT_ACK;
                end
                WAIT_ACK: if (ack_sel || to) begin
                    o_req0 <= 1'b0;
                    o_req1 <= 1'b0;
                    state  <= (ack_sel && !wr && !rstr_sel) ? WAIT_RDATA : IDLE;
                end
                WAIT_RDATA: if (rstr_sel || to) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/fm_int_dec.md
FM_INT_DEC -- requirements
Module: fm_int_dec

Interface
REQ-001 SHALL have parameter P_ADR_WIDTH, default 10: internal address width.
REQ-002 SHALL have parameter P_BE_WIDTH, default 4: byte-enable width.
REQ-003 SHALL have parameter P_DATA_WIDTH, default 32: data width.
REQ-004 SHALL have parameter P_TIMEOUT, default 8'd255: wait-cycle limit before abort.
REQ-005 SHALL have port clk_core  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_x  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_req  input  1  upstream request, held until o_ack.
REQ-008 SHALL have port i_wr  input  1  1=write, 0=read, valid with i_req.
REQ-009 SHALL have port i_adrs  input  P_ADR_WIDTH  request address; bit P_ADR_WIDTH-1 selects target.
REQ-010 SHALL have port i_be / i_wd  input  P_BE_WIDTH / P_DATA_WIDTH  write byte enables / write data.
REQ-011 SHALL have port o_ack  output  1  request accepted pulse to upstream.
REQ-012 SHALL have port o_rstr / o_rd  output  1 / P_DATA_WIDTH  read-data strobe / read data.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse on aborted transfer.
REQ-014 SHALL have ports o_req0 / o_req1  output  1  request to target 0 / target 1.
REQ-015 SHALL have ports o_wr0,o_adrs0,o_be0,o_wd0 / o_wr1,o_adrs1,o_be1,o_wd1  output  1,P_ADR_WIDTH,P_BE_WIDTH,P_DATA_WIDTH  registered command per target.
REQ-016 SHALL have ports i_ack0 / i_ack1  input  1  target acknowledge.
REQ-017 SHALL have ports i_rstr0,i_rd0 / i_rstr1,i_rd1  input  1,P_DATA_WIDTH  target read strobe / data.

Function
REQ-018 SHALL implement states IDLE, WAIT_ACK, WAIT_RDATA.
REQ-019 IDLE with i_req=1: SHALL latch wr/adrs/be/wd and select (i_adrs MSB) at the next edge, assert o_reqN of the selected target only, enter WAIT_ACK; 1-cycle request latency.
REQ-020 o_adrsN SHALL carry the full i_adrs; the unselected target's o_reqN SHALL stay 0.
REQ-021 WAIT_ACK: o_ack SHALL equal the selected i_ackN combinationally; o_reqN SHALL drop at the edge where i_ackN=1.
REQ-022 On ack, write -> IDLE; read with selected i_rstrN same cycle -> IDLE; read without -> WAIT_RDATA.
REQ-023 o_rstr/o_rd SHALL pass the selected i_rstrN/i_rdN combinationally in WAIT_ACK (with ack) and WAIT_RDATA; WAIT_RDATA -> IDLE on i_rstrN.
REQ-024 o_rstr SHALL be 0 in IDLE and for writes; o_rd SHALL be 0 when o_rstr=0.
REQ-025 Ack/strobe from the unselected target, or any ack/strobe in IDLE, SHALL be ignored.
REQ-026 After a transfer returns to IDLE, i_req still high in that first IDLE cycle (upstream drop latency) SHALL NOT start a new transfer; acceptance requires i_req=1 with o_ack low in the previous cycle.

Reset
REQ-027 rst_x low SHALL asynchronously force IDLE, o_req0/1=0, all registered command outputs and timeout counter to 0; o_ack, o_rstr, o_rd, o_timeout read 0.
REQ-028 Reset mid-transfer SHALL abandon it with no ack or strobe generated.

Configuration
REQ-029 With FM_INT_DEC_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering WAIT_ACK/WAIT_RDATA and count each cycle there; on reaching P_TIMEOUT without ack/strobe, SHALL drop o_reqN, pulse o_timeout and o_ack (WAIT_ACK) and, for reads, o_rstr with o_rd=32'hDEAD_BEEF (truncated to P_DATA_WIDTH), then go to IDLE.
REQ-030 Without FM_INT_DEC_TIMEOUT_EN: no counter, o_timeout tied 0, waits indefinitely.

Verification
REQ-031 Write i_adrs=10'h005, i_wd=32'h1234_5678, i_ack0 2 cycles after o_req0 -> o_req0 high 1 cycle after i_req, o_ack high the i_ack0 cycle, o_req1 never high.
REQ-032 Read i_adrs=10'h201, i_ack1 and i_rstr1 same cycle with i_rd1=32'hCAFE_0001 -> o_ack and o_rstr same cycle, o_rd=32'hCAFE_0001, back to IDLE.
REQ-033 Read target 0, i_ack0 then i_rstr0 3 cycles later -> single o_rstr pulse 3 cycles after o_ack; stray i_rstr1 meanwhile ignored.
REQ-034 TIMEOUT_EN, P_TIMEOUT=8'd4, target never acks a read -> o_req0 drops, o_ack, o_rstr, o_timeout pulse together with o_rd=32'hDEAD_BEEF.
REQ-035 rst_x low in WAIT_RDATA, then i_rstr0 after release -> no o_rstr, o_req0=0.
